// File: rtl/sprite_rom_pkg.sv
// sprite_rom_pkg: shared defaults and word types for the sprite ROM arbiter.
package sprite_rom_pkg;
  localparam int SPR_AW = 12;
  localparam int SPR_DW = 12;
  localparam int SPR_ROM_LAT = 2;
  typedef logic [SPR_AW-1:0] spr_addr_t;
  typedef logic [SPR_DW-1:0] spr_data_t;
endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: combinational round-robin pick; first set req at or after ptr, wrapping.
module arb_rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [N-1:0] rot;
  logic [IW:0]  sum;
  always_comb begin
    rot = N'({req, req} >> ptr);
    sum = '0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) sum = (IW+1)'(i);
    sum = sum + (IW+1)'(ptr);
    idx = sum >= (IW+1)'(N) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
    any = |req;
    win = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin sharing of one sync sprite ROM with burst lock and tagged fixed-latency return.
// Define SPRITE_ARB_FIXED_PRIO_EN to give requester 0 strict priority over everyone, locked owner included.
module sprite_rom_arbiter
  import sprite_rom_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int AW        = SPR_AW,
  parameter int DW        = SPR_DW,
  parameter int ROM_LAT   = SPR_ROM_LAT,
  parameter int MAX_BURST = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    lock,
  input  logic [N_REQ*AW-1:0] addr,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    rvalid,
  output logic [DW-1:0]       rdata,
  output logic                rom_en,
  output logic [AW-1:0]       rom_addr,
  input  logic [DW-1:0]       rom_data
);
  localparam int IW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
`ifdef SPRITE_ARB_FIXED_PRIO_EN
  localparam logic FIXED = 1'b1;
`else
  localparam logic FIXED = 1'b0;
`endif

  logic [IW-1:0]    ptr_q, ptr_d, owner_q, owner_d, pick_idx, gnt_idx;
  logic [BW-1:0]    burst_q, burst_d, beat;
  logic             locked_q, locked_d, hold, p0, pick_any, gnt_any, lk;
  logic [N_REQ-1:0] pick_win, rr_req;
  logic             rom_en_q, rom_en_d;
  logic [AW-1:0]    rom_addr_q, rom_addr_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [N_REQ-1:0] tag_q [ROM_LAT+1];
  logic [N_REQ-1:0] tag_d [ROM_LAT+1];

  arb_rr_pick #(.N(N_REQ)) u_pick (
    .req(rr_req),
    .ptr(ptr_q),
    .win(pick_win),
    .idx(pick_idx),
    .any(pick_any)
  );

  always_comb begin
    p0 = FIXED & req[0];
    rr_req = req & ~N_REQ'(FIXED);
    hold = locked_q & req[owner_q];
    gnt_any = rst_n & (p0 | hold | pick_any);
    gnt_idx = p0 ? '0 : hold ? owner_q : pick_idx;
    gnt = !rst_n ? '0 : p0 ? N_REQ'(1) : hold ? N_REQ'(1) << owner_q : pick_win;
    // the pointer only moves on a fresh round-robin win, so a lock expiring leaves the owner last in line
    ptr_d = (gnt_any & ~p0 & ~hold) ? (pick_idx == IW'(N_REQ - 1) ? '0 : pick_idx + 1'b1) : ptr_q;
    owner_d = gnt_any ? gnt_idx : owner_q;
    lk = gnt_any & ~p0 & lock[gnt_idx];
    beat = (hold ? burst_q : '0) + 1'b1;
    burst_d = lk ? beat : '0;
    locked_d = lk & (beat < BW'(MAX_BURST));
    rom_en_d = gnt_any;
    rom_addr_d = gnt_any ? addr[gnt_idx*AW +: AW] : rom_addr_q;
    tag_d[0] = gnt;
    for (int i = 1; i <= ROM_LAT; i++) tag_d[i] = tag_q[i-1];
    rdata_d = |tag_q[ROM_LAT-1] ? rom_data : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      owner_q <= '0;
      burst_q <= '0;
      locked_q <= 1'b0;
      rom_en_q <= 1'b0;
      rom_addr_q <= '0;
      rdata_q <= '0;
      tag_q <= '{default: '0};
    end else begin
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
      locked_q <= locked_d;
      rom_en_q <= rom_en_d;
      rom_addr_q <= rom_addr_d;
      rdata_q <= rdata_d;
      tag_q <= tag_d;
    end
  end

  assign rvalid = tag_q[ROM_LAT];
  assign rdata = rdata_q;
  assign rom_en = rom_en_q;
  assign rom_addr = rom_addr_q;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: vector table, reset corner sequences and a random run against a reference model.
module tb_sprite_rom_arbiter;
  import sprite_rom_pkg::*;
  localparam int N = 4;
  localparam int MAXB = 8;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req = '0, lock = '0, gnt, rvalid;
  logic [N*SPR_AW-1:0] addr = '0;
  spr_data_t rdata, rom_data = '0;
  logic rom_en;
  spr_addr_t rom_addr;

  sprite_rom_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .addr(addr),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  function automatic spr_data_t rom_f(spr_addr_t a);
    return (a * 12'd37) ^ 12'hA5C;
  endfunction

  // ROM model: data lands one cycle after rom_addr, in time for the return register
  always @(posedge clk) if (rom_en) rom_data <= rom_f(rom_addr);

  typedef struct { logic [N-1:0] oh; spr_addr_t a; } ret_t;
  typedef struct { logic [N-1:0] req, lock, gnt; } vec_t;

  ret_t sb[$];
  vec_t tbl[$];
  spr_addr_t addr_v [N];
  spr_addr_t exp_ra;
  logic exp_en;
  int n_pass = 0, n_total = 0;
  int gnt_cnt [N], rv_cnt [N], wait_c [N];
  int max_wait = 0;
  int m_ptr, m_owner, m_beats;
  bit m_locked;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  function automatic int oh_idx(logic [N-1:0] v);
    int k = 0;
    for (int i = 0; i < N; i++) if (v[i]) k = i;
    return k;
  endfunction

  // Reference arbitration: locked owner first, else scan from the pointer
  task automatic model_pick(input logic [N-1:0] r, input logic [N-1:0] l, output logic [N-1:0] eg);
    int w = -1;
    bit held = 1'b0;
    eg = '0;
    if (FIXED && r[0]) w = 0;
    else if (m_locked && r[m_owner]) begin w = m_owner; held = 1'b1; end
    else for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (w < 0 && r[i] && !(FIXED && i == 0)) w = i;
    end
    if (w < 0) m_locked = 1'b0;
    else begin
      eg[w] = 1'b1;
      if (!held && !(FIXED && w == 0)) m_ptr = (w + 1) % N;
      m_beats = (l[w] && !(FIXED && w == 0)) ? (held ? m_beats + 1 : 1) : 0;
      m_locked = m_beats > 0 && m_beats < MAXB;
      m_owner = w;
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N-1:0] eg, input string nm);
    ret_t e;
    @(posedge clk);
    #1;
    req = r;
    lock = l;
    for (int i = 0; i < N; i++) addr[i*SPR_AW +: SPR_AW] = addr_v[i];
    @(negedge clk);
    chk({nm, "_gnt"}, gnt, eg);
    chk("rom_en", rom_en, exp_en);
    chk("rom_addr", rom_addr, exp_ra);
    exp_en = |eg;
    if (|eg) exp_ra = addr_v[oh_idx(eg)];
    sb.push_back('{eg, exp_ra});
    e = sb.pop_front();
    chk("rvalid", rvalid, e.oh);
    if (|e.oh) chk("rdata", rdata, rom_f(e.a));
    for (int i = 0; i < N; i++) begin
      gnt_cnt[i] += int'(gnt[i]);
      rv_cnt[i] += int'(rvalid[i]);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req = '0;
    lock = '0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rom_en", rom_en, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_rdata", rdata, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    repeat (3) sb.push_back('{'0, '0});
    exp_en = 1'b0;
    exp_ra = '0;
    m_ptr = 0;
    m_owner = 0;
    m_beats = 0;
    m_locked = 1'b0;
    for (int i = 0; i < N; i++) begin gnt_cnt[i] = 0; rv_cnt[i] = 0; wait_c[i] = 0; end
  endtask

  initial begin
    logic [N-1:0] eg, r_cur, l_cur, eg_prev;
    do_reset();
`ifdef SPRITE_ARB_FIXED_PRIO_EN
    tbl.push_back('{4'b0001, 4'b0000, 4'b0001});
    repeat (3) tbl.push_back('{4'b1111, 4'b0100, 4'b0001});
    tbl.push_back('{4'b1110, 4'b0000, 4'b0010});
    tbl.push_back('{4'b1110, 4'b0000, 4'b0100});
    tbl.push_back('{4'b1110, 4'b0000, 4'b1000});
    tbl.push_back('{4'b1110, 4'b0000, 4'b0010});
    tbl.push_back('{4'b0100, 4'b0100, 4'b0100});
    tbl.push_back('{4'b0101, 4'b0100, 4'b0001});
    tbl.push_back('{4'b0100, 4'b0100, 4'b0100});
`else
    tbl.push_back('{4'b0001, 4'b0000, 4'b0001});
    tbl.push_back('{4'b1111, 4'b0000, 4'b0010});
    tbl.push_back('{4'b1111, 4'b0000, 4'b0100});
    tbl.push_back('{4'b1111, 4'b0000, 4'b1000});
    tbl.push_back('{4'b1111, 4'b0000, 4'b0001});
    tbl.push_back('{4'b1111, 4'b0000, 4'b0010});
    tbl.push_back('{4'b0110, 4'b0010, 4'b0100});
    repeat (8) tbl.push_back('{4'b0110, 4'b0010, 4'b0010});
    tbl.push_back('{4'b0110, 4'b0010, 4'b0100});
    tbl.push_back('{4'b0110, 4'b0010, 4'b0010});
    tbl.push_back('{4'b0000, 4'b0000, 4'b0000});
    tbl.push_back('{4'b1000, 4'b0000, 4'b1000});
`endif
    for (int r = 0; r < tbl.size(); r++) begin
      for (int i = 0; i < N; i++) addr_v[i] = spr_addr_t'(i * 'h111 + 'h123 + r * 5);
      step(tbl[r].req, tbl[r].lock, tbl[r].gnt, "tbl");
    end
    repeat (4) step('0, '0, '0, "tbl_drain");

    do_reset();
    for (int k = 0; k < 5; k++) begin
      model_pick(4'b1111, '0, eg);
      step(4'b1111, '0, eg, "pre_rst");
    end
    do_reset();
    model_pick(4'b1111, '0, eg);
    step(4'b1111, '0, 4'b0001, "post_rst_first");
    repeat (4) step('0, '0, '0, "post_rst_idle");

    do_reset();
    r_cur = '0;
    eg_prev = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!r_cur[i] || eg_prev[i]) begin
          r_cur[i] = $urandom_range(0, 2) != 0;
          addr_v[i] = spr_addr_t'($urandom);
        end else if ($urandom_range(0, 31) == 0) r_cur[i] = 1'b0;
        l_cur[i] = 1'($urandom_range(0, 1));
      end
      model_pick(r_cur, l_cur, eg);
      for (int i = 0; i < N; i++) begin
        wait_c[i] = (r_cur[i] && !eg[i]) ? wait_c[i] + 1 : 0;
        if (wait_c[i] > max_wait) max_wait = wait_c[i];
      end
      step(r_cur, l_cur, eg, "rand");
      eg_prev = eg;
    end
    repeat (4) step('0, '0, '0, "rand_drain");
    for (int i = 0; i < N; i++) chk($sformatf("count_%0d", i), rv_cnt[i], gnt_cnt[i]);
`ifndef SPRITE_ARB_FIXED_PRIO_EN
    chk("starvation_bound", max_wait <= (N - 1) * MAXB + N, 1);
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
